// File: rtl/capp_pkg.sv
// Shared CAPP definitions: array geometry defaults and the resolver state encoding.
// Used by the compare, cells, tags and match resolver blocks.
package capp_pkg;

  localparam int WORDS = 100;
  localparam int WIDTH = 32;
  localparam int IDX_W = 7;
  localparam int CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ffs_lsb.sv
// Find-first-set with LSB priority: reports the lowest set bit of in_vec as a
// one-hot vector and as a binary index. found is low when in_vec is all zero,
// in which case onehot and index are both zero.
module ffs_lsb #(
  parameter int N  = 100,
  parameter int IW = 7
) (
  input  logic [N-1:0]  in_vec,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] index,
  output logic          found
);

  // Scan from the top down so the last hit written is the lowest set bit.
  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_vec[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        index     = IW'(i);
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/match_resolver.sv
// Match resolver: latches the per-word match lines into a tag register on start,
// then walks the matching words lowest-index-first. For each one it drives a
// one-hot word select into the cell array, captures the returned data and
// presents (index, data) on a valid/ready output. A one-cycle done pulse marks
// the end of the result set.
module match_resolver #(
  parameter int WORDS = capp_pkg::WORDS,
  parameter int WIDTH = capp_pkg::WIDTH,
  parameter int IDX_W = capp_pkg::IDX_W,
  parameter int CNT_W = capp_pkg::CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [WORDS-1:0] match_lines,
  output logic [WORDS-1:0] word_select,
  input  logic [WIDTH-1:0] read_lines,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic             any_match,
  output logic [CNT_W-1:0] match_count
);

  import capp_pkg::*;

  state_t           state;
  logic [WORDS-1:0] tags;
  logic [WORDS-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_index;
  logic             pick_found;
  logic             slot_free;
  logic             pick;
  logic [CNT_W-1:0] line_count;

  ffs_lsb #(
    .N  (WORDS),
    .IW (IDX_W)
  ) u_ffs (
    .in_vec (tags),
    .onehot (pick_onehot),
    .index  (pick_index),
    .found  (pick_found)
  );

  // Popcount of the incoming match lines, only captured when a search starts.
  always_comb begin
    line_count = '0;
    for (int i = 0; i < WORDS; i++) begin
      line_count = line_count + {{(CNT_W-1){1'b0}}, match_lines[i]};
    end
  end

  // A new word is read whenever the output slot is empty or being drained this
  // edge, so with the consumer always ready one result moves per cycle.
  always_comb begin
    slot_free   = !out_valid || out_ready;
    pick        = (state == SCAN) && pick_found && slot_free && !RST;
    word_select = pick ? pick_onehot : '0;
    busy        = (state == SCAN) || (state == DONE);
  end

  // Resolver FSM: capture the set, stream one result per free slot, pulse done.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      tags        <= '0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      out_data    <= '0;
      done        <= 1'b0;
      any_match   <= 1'b0;
      match_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tags        <= match_lines;
            any_match   <= |match_lines;
            match_count <= line_count;
            state       <= SCAN;
          end
        end
        SCAN: begin
          if (pick) begin
            out_index <= pick_index;
            out_data  <= read_lines;
            out_valid <= 1'b1;
            tags      <= tags & ~pick_onehot;
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
          if (!pick_found && slot_free) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_resolver.sv
// Directed bench for match_resolver: a small cell-array model answers word
// selects, expected results are queued when a search starts and checked as the
// consumer accepts them.
module tb_match_resolver;

  import capp_pkg::*;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] data;
  } result_t;

  logic             CLK = 1'b0;
  logic             RST;
  logic             start;
  logic [WORDS-1:0] match_lines;
  logic [WORDS-1:0] word_select;
  logic [WIDTH-1:0] read_lines;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [WIDTH-1:0] out_data;
  logic             busy;
  logic             done;
  logic             any_match;
  logic [CNT_W-1:0] match_count;

  int      checks      = 0;
  int      errors      = 0;
  int      accepted    = 0;
  int      done_pulses = 0;
  result_t expq[$];

  match_resolver dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .match_lines (match_lines),
    .word_select (word_select),
    .read_lines  (read_lines),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_index   (out_index),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .any_match   (any_match),
    .match_count (match_count)
  );

  // 10 ns clock.
  always #5 CLK = ~CLK;

  function automatic logic [WIDTH-1:0] cell_data(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {16'hC0DE, b, ~b};
  endfunction

  // Cell array model: OR of the contents of every selected word.
  always_comb begin
    read_lines = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (word_select[i]) read_lines = read_lines | cell_data(i);
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted result must be the oldest expected one.
  always @(negedge CLK) begin : monitor
    result_t e;
    if (!RST && done === 1'b1) done_pulses++;
    if (!RST && out_valid === 1'b1 && out_ready === 1'b1) begin
      accepted++;
      if (expq.size() == 0) begin
        checkOutput("unexpected_result_queue_size", 128'(expq.size()), 128'd1);
      end else begin
        e = expq.pop_front();
        checkOutput("result_index", 128'(out_index), 128'(e.idx));
        checkOutput("result_data", 128'(out_data), 128'(e.data));
      end
    end
  end

  // Start a search and queue its expected results; returns 1 ns after the
  // edge that sampled start. match_lines is then scrambled on purpose.
  task automatic applyStimulus(input logic [WORDS-1:0] ml);
    result_t r;
    match_lines = ml;
    start       = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      if (ml[i]) begin
        r.idx  = IDX_W'(i);
        r.data = cell_data(i);
        expq.push_back(r);
      end
    end
    @(posedge CLK); #1;
    start       = 1'b0;
    match_lines = ~ml;
  endtask

  task automatic waitDone(input int budget, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge CLK); #1;
      n++;
    end
    checkOutput(tag, 128'(done), 128'd1);
  endtask

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [WORDS-1:0] ml;
    logic [WORDS-1:0] ws_exp;
    int               acc0;
    int               dp0;

    RST         = 1'b1;
    start       = 1'b0;
    match_lines = '0;
    out_ready   = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_out_index", 128'(out_index), 128'd0);
    checkOutput("reset_out_data", 128'(out_data), 128'd0);
    checkOutput("reset_done", 128'(done), 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_any_match", 128'(any_match), 128'd0);
    checkOutput("reset_match_count", 128'(match_count), 128'd0);
    checkOutput("reset_word_select", 128'(word_select), 128'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Three sparse matches, consumer always ready.
    $display("[TB] three matches 3/17/99");
    ml = '0; ml[3] = 1'b1; ml[17] = 1'b1; ml[99] = 1'b1;
    applyStimulus(ml);
    ws_exp = '0; ws_exp[3] = 1'b1;
    checkOutput("t1_word_select_first", 128'(word_select), 128'(ws_exp));
    checkOutput("t1_no_valid_yet", 128'(out_valid), 128'd0);
    @(posedge CLK); #1;
    checkOutput("t1_first_valid", 128'(out_valid), 128'd1);
    checkOutput("t1_first_index", 128'(out_index), 128'd3);
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("t1_done", 128'(done), 128'd1);
    checkOutput("t1_match_count", 128'(match_count), 128'd3);
    checkOutput("t1_any_match", 128'(any_match), 128'd1);
    checkOutput("t1_queue_drained", 128'(expq.size()), 128'd0);
    @(posedge CLK); #1;
    checkOutput("t1_done_one_cycle", 128'(done), 128'd0);
    checkOutput("t1_idle_busy", 128'(busy), 128'd0);

    // No matches at all.
    $display("[TB] zero matches");
    applyStimulus('0);
    checkOutput("t2_busy_scan", 128'(busy), 128'd1);
    @(posedge CLK); #1;
    checkOutput("t2_done", 128'(done), 128'd1);
    checkOutput("t2_any_match", 128'(any_match), 128'd0);
    checkOutput("t2_match_count", 128'(match_count), 128'd0);
    checkOutput("t2_no_valid", 128'(out_valid), 128'd0);
    @(posedge CLK); #1;
    checkOutput("t2_done_cleared", 128'(done), 128'd0);

    // Backpressure on the first of two results.
    $display("[TB] backpressure 5/6");
    out_ready = 1'b0;
    ml = '0; ml[5] = 1'b1; ml[6] = 1'b1;
    applyStimulus(ml);
    @(posedge CLK); #1;
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3_stall_valid", 128'(out_valid), 128'd1);
      checkOutput("t3_stall_index", 128'(out_index), 128'd5);
      checkOutput("t3_stall_data", 128'(out_data), 128'(cell_data(5)));
      checkOutput("t3_stall_word_select", 128'(word_select), 128'd0);
      @(posedge CLK); #1;
    end
    out_ready = 1'b1;
    #1;
    ws_exp = '0; ws_exp[6] = 1'b1;
    checkOutput("t3_release_select", 128'(word_select), 128'(ws_exp));
    @(posedge CLK); #1;
    checkOutput("t3_second_index", 128'(out_index), 128'd6);
    waitDone(10, "t3_done_timeout");
    checkOutput("t3_queue_drained", 128'(expq.size()), 128'd0);
    @(posedge CLK); #1;

    // Every word matches.
    $display("[TB] all words match");
    acc0 = accepted;
    dp0  = done_pulses;
    applyStimulus('1);
    waitDone(150, "t4_done_timeout");
    checkOutput("t4_match_count", 128'(match_count), 128'(WORDS));
    checkOutput("t4_queue_drained", 128'(expq.size()), 128'd0);
    @(posedge CLK); #1;
    checkOutput("t4_result_total", 128'(accepted - acc0), 128'(WORDS));
    checkOutput("t4_done_pulses", 128'(done_pulses - dp0), 128'd1);
    checkOutput("t4_done_cleared", 128'(done), 128'd0);

    // start repeated mid-scan must be ignored.
    $display("[TB] restart ignored mid-scan");
    ml = '0; ml[1] = 1'b1; ml[2] = 1'b1; ml[50] = 1'b1; ml[60] = 1'b1;
    applyStimulus(ml);
    @(posedge CLK); #1;
    checkOutput("t5_first_index", 128'(out_index), 128'd1);
    match_lines     = '0;
    match_lines[7]  = 1'b1;
    start           = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    waitDone(20, "t5_done_timeout");
    checkOutput("t5_match_count", 128'(match_count), 128'd4);
    checkOutput("t5_queue_drained", 128'(expq.size()), 128'd0);
    @(posedge CLK); #1;

    // Reset in the middle of a scan.
    $display("[TB] reset mid-scan 10/20/30");
    ml = '0; ml[10] = 1'b1; ml[20] = 1'b1; ml[30] = 1'b1;
    applyStimulus(ml);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checkOutput("t6_at_index_20", 128'(out_index), 128'd20);
    dp0       = done_pulses;
    RST       = 1'b1;
    out_ready = 1'b0;
    #1;
    checkOutput("t6_reset_word_select", 128'(word_select), 128'd0);
    @(posedge CLK); #1;
    checkOutput("t6_out_valid", 128'(out_valid), 128'd0);
    checkOutput("t6_out_index", 128'(out_index), 128'd0);
    checkOutput("t6_out_data", 128'(out_data), 128'd0);
    checkOutput("t6_busy", 128'(busy), 128'd0);
    checkOutput("t6_match_count", 128'(match_count), 128'd0);
    checkOutput("t6_any_match", 128'(any_match), 128'd0);
    RST       = 1'b0;
    out_ready = 1'b1;
    expq.delete();
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("t6_no_done_after_reset", 128'(done_pulses - dp0), 128'd0);
    checkOutput("t6_idle_after_reset", 128'(busy), 128'd0);
    ml = '0; ml[0] = 1'b1; ml[99] = 1'b1;
    applyStimulus(ml);
    waitDone(10, "t6_fresh_done_timeout");
    checkOutput("t6_fresh_match_count", 128'(match_count), 128'd2);
    checkOutput("t6_fresh_queue_drained", 128'(expq.size()), 128'd0);
    @(posedge CLK); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
